// File: rtl/dmem_responder.sv
// Load/store data-memory responder: one request at a time, WAIT_STATES wait cycles, RV32I sized access.
// Optional access-fault reporting is enabled by defining DMEM_ERR_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        lat_write;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             is_byte;
  logic             is_half;
  logic             fault;
  logic             access_ok;
  logic             access_fire;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_data;
  logic [3:0]       byte_en;
  logic [31:0]      wr_lanes;

  // Everything below decodes the latched request, so late input changes cannot leak in.
  assign offset      = lat_addr - ADDR_BASE;
  assign in_range    = {1'b0, offset} < SPAN;
  assign idx         = offset[IDX_W+1:2];
  assign is_byte     = (lat_funct3[1:0] == 2'b00);
  assign is_half     = (lat_funct3[1:0] == 2'b01);
  assign access_fire = (state == WAIT) && (wait_cnt == 4'd0);

`ifdef DMEM_ERR_EN
  logic misaligned;
  logic reserved;
  logic err_q;

  assign reserved   = (lat_funct3 == 3'b011) || (lat_funct3[2:1] == 2'b11);
  assign misaligned = (is_half && lat_addr[0]) ||
                      (!is_byte && !is_half && (lat_addr[1:0] != 2'b00));
  assign fault      = misaligned || reserved || !in_range;
  assign rsp_err    = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (access_fire) begin
      err_q <= fault;
    end
  end
`else
  assign fault   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign access_ok = in_range && !fault;

  always_comb begin
    rd_word   = mem[idx];
    rd_byte   = rd_word[{lat_addr[1:0], 3'b000} +: 8];
    rd_half   = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    byte_en   = 4'b1111;
    wr_lanes  = lat_wdata;
    if (is_byte) begin
      load_data = lat_funct3[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      byte_en   = 4'b0001 << lat_addr[1:0];
      wr_lanes  = {4{lat_wdata[7:0]}};
    end else if (is_half) begin
      load_data = lat_funct3[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      byte_en   = lat_addr[1] ? 4'b1100 : 4'b0011;
      wr_lanes  = {2{lat_wdata[15:0]}};
    end
    if (!access_ok) begin
      load_data = 32'h0;
    end
  end

  // NOTE: the array has no reset branch; clearing storage on reset is not required and
  // would stop it mapping to RAM. Reset still blocks commits because it forces state to IDLE.
  always_ff @(posedge clk) begin
    if (access_fire && lat_write && access_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      lat_write  <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            wait_cnt   <= 4'(WAIT_STATES);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            rdata_q <= lat_write ? 32'h0 : load_data;
            state   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, scoreboard queue and hand-written corner sequences.
module tb_dmem_responder;

  localparam int unsigned WS = 2;
`ifdef DMEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS), .ADDR_BASE(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_rsp(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({name, " rdata"}, rsp_rdata, e.rdata);
      check({name, " err"}, {31'h0, rsp_err}, {31'h0, e.err});
    end
  endtask

  // Waits on negedges until rsp_valid; returns edges waited and cycles seen with req_ready low.
  task automatic wait_rsp(output int lat, output int busy);
    lat  = 0;
    busy = 0;
    while (!rsp_valid && lat < 100) begin
      if (!req_ready) busy++;
      @(negedge clk);
      lat++;
    end
    if (!req_ready) busy++;
    if (!rsp_valid) check("rsp_valid timeout", 32'd0, 32'd1);
  endtask

  task automatic run_txn(input string name, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, output int busy);
    int n;
    int lat;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rsp_ready  = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check({name, " req_ready timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = ~wr;
    wait_rsp(lat, busy);
    check({name, " latency"}, lat, WS + 1);
    compare_rsp(name);
    @(posedge clk);
  endtask

  initial begin
    int   busy;
    int   lat;
    logic [31:0] held;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset req_ready", {31'h0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'h0, rsp_err}, 32'd0);
    rst = 1'b0;

    run_txn("clr 0x00", 1'b1, 3'b010, 32'h00, 32'h0, 32'h0, 1'b0, busy);
    run_txn("clr 0x10", 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, busy);
    run_txn("clr 0x20", 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, busy);
    run_txn("clr 0x40", 1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, busy);

    // Basic store/load with latency and busy-window measurement.
    run_txn("sw 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, busy);
    check("sw busy cycles", busy, WS + 2);
    run_txn("lw 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, busy);
    check("lw busy cycles", busy, WS + 2);

    // Reset while a store waits: the store must never reach the array.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst-in-wait req_ready", {31'h0, req_ready}, 32'd1);
    check("rst-in-wait rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst-in-wait rsp_rdata", rsp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_txn("lw 0x40 after rst", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, busy);

    vecs.push_back('{1'b1, 3'b000, 32'h13, 32'hFFFFFF80, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h12, 32'h0,        32'h000080AD, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF80AD, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 32'h22, 32'hFFFF1234, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h22, 32'h0,        32'h00001234, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h20, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h20, 32'h0,        32'h12340000, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 32'h40, 32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h41, 32'h0,        ERR ? 32'h0 : 32'h11223344, ERR});
    vecs.push_back('{1'b0, 3'b001, 32'h13, 32'h0,        ERR ? 32'h0 : 32'hFFFF80AD, ERR});
    vecs.push_back('{1'b0, 3'b011, 32'h10, 32'h0,        ERR ? 32'h0 : 32'h80ADBEEF, ERR});
    vecs.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,      32'h0,        ERR});
    vecs.push_back('{1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0,      ERR});
    vecs.push_back('{1'b0, 3'b010, 32'h00, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b100, 32'h42, 32'h0,        32'h00000022, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 32'h41, 32'h00005566, 32'h0,        ERR});
    vecs.push_back('{1'b0, 3'b010, 32'h40, 32'h0,        ERR ? 32'h11223344 : 32'h11225566, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].f3, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, busy);
    end

    // Response back-pressure with a second request held on the request port.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk);
    sb_q.push_back('{rdata: 32'h80ADBEEF, err: 1'b0});
    @(negedge clk);
    req_addr = 32'h20;
    wait_rsp(lat, busy);
    held = rsp_rdata;
    compare_rsp("stall first");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall rsp_valid %0d", i), {31'h0, rsp_valid}, 32'd1);
      check($sformatf("stall rdata %0d", i), rsp_rdata, 32'h80ADBEEF);
      check($sformatf("stall req_ready %0d", i), {31'h0, req_ready}, 32'd0);
    end
    check("stall rdata held", rsp_rdata, held);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post-handshake req_ready", {31'h0, req_ready}, 32'd1);
    check("post-handshake rsp_valid", {31'h0, rsp_valid}, 32'd0);
    @(posedge clk);
    sb_q.push_back('{rdata: 32'h12340000, err: 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    check("held req accepted", {31'h0, req_ready}, 32'd0);
    wait_rsp(lat, busy);
    check("held req latency", lat, WS + 1);
    compare_rsp("stall second");
    @(posedge clk);
    @(negedge clk);

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the processor's load/store port, with a valid/ready request/response handshake. It latches one request at a time and inserts a configurable number of wait states. It performs RV32I byte, halfword and word accesses on a word-organised array, and returns sign- or zero-extended load data. It sits between the core's load/store path and data storage, and is the precursor to a multi-cycle or pipelined memory system.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
WAIT_STATES, 2, extra cycles between request acceptance and data access (0..15)
ADDR_BASE, 32'h0000_0000, byte address of word 0

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  extended load data; 0 for stores
rsp_err  out  1  access fault (only with optional feature; else constant 0)

Behaviour:
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE). rsp_valid = (state==RESP).
- rst asserted: state=IDLE, wait counter=0, rsp_rdata=0, rsp_err=0, latched request cleared. Array contents are not reset.
- IDLE: on req_valid & req_ready at an edge, latch write, funct3, addr and wdata, load counter=WAIT_STATES, go to WAIT. Input changes after acceptance are ignored.
- WAIT: if counter!=0, decrement. If counter==0, perform the access at the next edge and go to RESP.
- Latency: rsp_valid rises WAIT_STATES+1 edges after the accepting edge.
- RESP: rsp_rdata and rsp_err hold stable until rsp_valid & rsp_ready; then go to IDLE. Maximum throughput is one transaction per WAIT_STATES+3 cycles.
- Word index = (addr-ADDR_BASE)>>2, width clog2(DEPTH_WORDS).
- Out of range ((addr-ADDR_BASE) >= DEPTH_WORDS*4, unsigned): store dropped, load returns 0.
- Stores:
  - SB writes wdata[7:0] to lane addr[1:0].
  - SH writes wdata[15:0] to lane addr[1] (bytes 2*addr[1] and 2*addr[1]+1).
  - SW writes the full word.
  - Other lanes are unchanged. rsp_rdata=0.
- Loads:
  - LB and LBU select byte addr[1:0], sign- or zero-extended.
  - LH and LHU select half addr[1], sign- or zero-extended.
  - LW returns the full word.
- Reserved funct3 (011, 110, 111): treated as word access.
- Reset during WAIT: the pending store is never committed. Reset during RESP: the response is discarded.
- req_valid held during WAIT/RESP is not accepted until IDLE.

Optional Feature:
DMEM_ERR_EN
- Defined:
  - Misaligned halfword (addr[0]=1), misaligned word (addr[1:0]!=0), out-of-range, or reserved funct3 sets rsp_err=1 in RESP.
  - On a fault, the store is suppressed and rsp_rdata=0.
  - rsp_err is 0 for valid accesses.
- Undefined:
  - rsp_err is tied 0.
  - Misaligned addresses are forced aligned: halfword ignores addr[0]; word ignores addr[1:0].
  - Out-of-range and reserved funct3 behave as described in Behaviour.

Test Plan:
1. WAIT_STATES=2; SW 0xDEADBEEF to 0x10, then LW 0x10 with rsp_ready=1 -> rsp_valid rises 3 edges after accept; rdata=0xDEADBEEF; req_ready low for 4 cycles per transaction.
2. SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
3. SH 0x1234 to 0x22, then LH 0x22 -> 0x00001234; LHU 0x20 -> 0x00000000 (fresh word cleared before the test).
4. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready=0; new req_valid is not accepted until one cycle after the rsp handshake.
5. Issue SW 0xA5A5A5A5 to 0x40; assert rst in WAIT -> outputs at reset values; subsequent LW 0x40 returns the prior value, 0x00000000.
6. DMEM_ERR_EN defined: LW 0x41 -> rsp_err=1, rdata=0; SW to DEPTH_WORDS*4 -> rsp_err=1, no array change. Undefined: LW 0x41 returns word 0x40, rsp_err=0.
